// File: rtl/spi_frame_rx_pkg.sv
// rtl/spi_frame_rx_pkg.sv - shared types and constants for the SPI frame receiver
package spi_frame_rx_pkg;

    // Receiver sequencing: WAIT_IDLE swallows a frame already in flight at reset release
    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        ACTIVE    = 2'd2,
        CLOSE     = 2'd3
    } rx_state_t;

    localparam int DEFAULT_FRAME_BITS = 16;
    localparam int ERR_CNT_W          = 8;

endpackage

// File: rtl/spi_frame_rx_pad_sync.sv
// rtl/spi_frame_rx_pad_sync.sv - multi-flop synchroniser for one raw pad input
module pad_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] chain;

    // Shift the pad value through the chain; reset to the pad's idle level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], din};
        end
    end

    assign dout = chain[STAGES-1];

endmodule

// File: rtl/spi_frame_rx.sv
// rtl/spi_frame_rx.sv - oversampled SPI-slave frame receiver; optional SPI_RX_ERR_CNT_EN adds err_count
module spi_frame_rx
    import spi_frame_rx_pkg::*;
#(
    parameter int FRAME_BITS  = DEFAULT_FRAME_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sck_in,
    input  logic                  cs_n_in,
    input  logic                  mosi_in,
    output logic [FRAME_BITS-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  overrun,
`ifdef SPI_RX_ERR_CNT_EN
    output logic                  frame_err,
    output logic [ERR_CNT_W-1:0]  err_count
`else
    output logic                  frame_err
`endif
);

    localparam int CNT_W = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS + 1);

    // Cycles after reset before the synchronised cs_n reflects the pad
    localparam int SET_W = $clog2(SYNC_STAGES + 3);
    localparam logic [SET_W-1:0] SETTLE = SET_W'(SYNC_STAGES + 2);

    logic sck_s, cs_s, mosi_s;
    logic sck_d, cs_d, mosi_d;
    logic sck_rise, cs_rise, cs_fall;
    logic [SET_W-1:0] settle_cnt;
    logic settled;

    rx_state_t state_q, state_d;
    logic clr_frame, shift_en;
    logic [FRAME_BITS-1:0] shift_q;
    logic [CNT_W-1:0] bit_cnt;
    logic good_frame, bad_frame;

    pad_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rst_n(rst_n), .din(sck_in), .dout(sck_s)
    );

    pad_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .din(cs_n_in), .dout(cs_s)
    );

    pad_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .din(mosi_in), .dout(mosi_s)
    );

    // History flops and registered edge pulses; mosi_d keeps data aligned with the sck pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_d    <= 1'b0;
            cs_d     <= 1'b1;
            mosi_d   <= 1'b0;
            sck_rise <= 1'b0;
            cs_rise  <= 1'b0;
            cs_fall  <= 1'b0;
        end else begin
            sck_d    <= sck_s;
            cs_d     <= cs_s;
            mosi_d   <= mosi_s;
            sck_rise <= sck_s & ~sck_d;
            cs_rise  <= cs_s & ~cs_d;
            cs_fall  <= ~cs_s & cs_d;
        end
    end

    // Hold off leaving WAIT_IDLE until the reset value has flushed out of the cs_n chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
        end else if (settle_cnt != SETTLE) begin
            settle_cnt <= settle_cnt + 1'b1;
        end
    end

    assign settled = (settle_cnt == SETTLE);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath control; cs_n release wins over a coincident sck edge
    always_comb begin
        state_d   = state_q;
        clr_frame = 1'b0;
        shift_en  = 1'b0;
        case (state_q)
            WAIT_IDLE: begin
                if (settled && cs_s) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (cs_fall) begin
                    state_d   = ACTIVE;
                    clr_frame = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d = CLOSE;
                end else if (sck_rise) begin
                    shift_en = 1'b1;
                end
            end
            CLOSE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = WAIT_IDLE;
            end
        endcase
    end

    // Shift register and saturating bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            bit_cnt <= '0;
        end else if (clr_frame) begin
            shift_q <= '0;
            bit_cnt <= '0;
        end else if (shift_en) begin
            shift_q <= {shift_q[FRAME_BITS-2:0], mosi_d};
            if (bit_cnt != CNT_MAX) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    assign good_frame = (state_q == CLOSE) && (bit_cnt == CNT_FULL);
    assign bad_frame  = (state_q == CLOSE) && (bit_cnt != CNT_FULL) && (bit_cnt != '0);

    // Output handshake, frame delivery and one-cycle error pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            overrun   <= 1'b0;
            frame_err <= bad_frame;
            if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
            if (good_frame) begin
                if (!data_valid || data_ready) begin
                    data_out   <= shift_q;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

`ifdef SPI_RX_ERR_CNT_EN
    // Saturating count of overrun and framing-error pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if ((overrun || frame_err) && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
        end
    end
`endif

endmodule
